speck_inv_round: RTL

SPECK_INV_ROUND -- requirements
Module: speck_inv_round

---
 rtl/speck_inv_round.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/speck_inv_round.sv
// speck_inv_round: one SPECK inverse round, subtraction done bit-serially.
//
// Accepts (x_in, y_in, k_in) in IDLE. It then computes
//   y_out = ror(x_in ^ y_in, BETA)
//   x_out = rol(((x_in ^ k_in) - y_out) mod 2^WORD, ALPHA)
// The subtraction runs one bit per cycle, LSB first, as a + ~b + 1. It uses a
// majority/inverter full-adder cell.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// and x_out/y_out/out_valid hold stable in DONE until the transfer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for x_in, y_in, k_in (WORD bits each)
//   out_valid/out_ready output handshake for x_out, y_out (WORD bits each)
//   busy                high while a round is in SUB or DONE
module speck_inv_round #(
  parameter int WORD  = 16,
  parameter int ALPHA = 7,
  parameter int BETA  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] x_in,
  input  logic [WORD-1:0] y_in,
  input  logic [WORD-1:0] k_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] x_out,
  output logic [WORD-1:0] y_out,
  output logic            busy
);

  localparam int CW = (WORD > 1) ? $clog2(WORD) : 1;
  localparam int AR = ALPHA % WORD;
  localparam int BR = BETA % WORD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WORD-1:0] a_q;     // minuend, shifted right one bit per SUB cycle
  logic [WORD-1:0] b_q;     // subtrahend, shifted right alongside a_q
  logic [WORD-2:0] diff_q;  // difference bits collected so far, MSB-inserted
  logic [CW-1:0]   cnt_q;
  logic            carry_q;

  function automatic logic maj(input logic p, input logic q, input logic r);
    return (p & q) | (p & r) | (q & r);
  endfunction

  function automatic logic [WORD-1:0] rol_f(input logic [WORD-1:0] v, input int n);
    return (v << n) | (v >> (WORD - n));
  endfunction

  function automatic logic [WORD-1:0] ror_f(input logic [WORD-1:0] v, input int n);
    return (v >> n) | (v << (WORD - n));
  endfunction

  // Full-adder cell on a[i], ~b[i] and the carry, built only from majority
  // gates and inverters. sum = maj(~cout, maj(a, nb, ~c), c).
  logic            bit_a, bit_nb, bit_c, bit_cout, bit_sum, last_bit;
  logic [WORD-1:0] diff_full;

  always_comb begin
    bit_a     = a_q[0];
    bit_nb    = ~b_q[0];
    bit_c     = carry_q;
    bit_cout  = maj(bit_a, bit_nb, bit_c);
    bit_sum   = maj(~bit_cout, maj(bit_a, bit_nb, ~bit_c), bit_c);
    last_bit  = (cnt_q == CW'(WORD - 1));
    diff_full = {bit_sum, diff_q};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = SUB;
      end
      SUB: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. The final carry out of bit WORD-1 is simply dropped, so the
  // difference wraps modulo 2^WORD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b1;
      x_out   <= '0;
      y_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= x_in ^ k_in;
            b_q     <= ror_f(x_in ^ y_in, BR);
            y_out   <= ror_f(x_in ^ y_in, BR);
            cnt_q   <= '0;
            carry_q <= 1'b1;
          end
        end
        SUB: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          diff_q  <= diff_full[WORD-1:1];
          carry_q <= bit_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) x_out <= rol_f(diff_full, AR);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
